// File: rtl/remote_update_pkg.sv
// Shared types and widths for the remote-update command sequencer.
package remote_update_pkg;

    localparam int RU_DATA_W  = 24;
    localparam int RU_PARAM_W = 3;
    localparam int RU_SRC_W   = 2;

    typedef enum logic [1:0] {
        OP_READ_PARAM  = 2'd0,
        OP_WRITE_PARAM = 2'd1,
        OP_RECONFIG    = 2'd2,
        OP_RSVD        = 2'd3
    } ru_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_RESP,
        ST_RECONF
    } ru_state_e;

endpackage

// File: rtl/remote_update_ctrl_wdt.sv
// Watchdog kick generator: toggles kick every KICK_CYCLES enabled cycles.
module ru_wdt_kick #(
    parameter int unsigned KICK_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic kick
);

    localparam int CNT_W = (KICK_CYCLES > 1) ? $clog2(KICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            kick <= 1'b0;
        end else if (en) begin
            if (cnt == CNT_LAST) begin
                cnt  <= '0;
                kick <= ~kick;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/remote_update_ctrl.sv
// Command sequencer for altera_remote_update_core.
// Define REMOTE_UPDATE_WDT_EN to let this block own the watchdog kick.
module remote_update_ctrl
    import remote_update_pkg::*;
#(
    parameter int unsigned           BUSY_TIMEOUT    = 1024,
    parameter logic [RU_DATA_W-1:0]  RECONFIG_KEY    = 24'hA5C3E1,
    parameter int unsigned           RECONFIG_HOLD   = 16,
    parameter int unsigned           WDT_KICK_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [RU_PARAM_W-1:0] cmd_param,
    input  logic [RU_SRC_W-1:0]   cmd_src,
    input  logic [RU_DATA_W-1:0]  cmd_data,
    output logic                  rsp_valid,
    output logic [RU_DATA_W-1:0]  rsp_data,
    output logic                  rsp_err,
    output logic                  ru_read_param,
    output logic                  ru_write_param,
    output logic [RU_PARAM_W-1:0] ru_param,
    output logic [RU_SRC_W-1:0]   ru_read_source,
    output logic [RU_DATA_W-1:0]  ru_data_in,
    output logic                  ru_reconfig,
    output logic                  ru_reset_timer,
    input  logic                  ru_busy,
    input  logic [RU_DATA_W-1:0]  ru_data_out
);

    localparam int TO_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam int HOLD_W = $clog2(RECONFIG_HOLD + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RECONFIG_HOLD - 1);

    if (BUSY_TIMEOUT < 2 || RECONFIG_HOLD < 1 || WDT_KICK_CYCLES < 1)
    begin : g_bad_cfg
        $error("remote_update_ctrl: invalid parameter value");
    end

    ru_state_e         state;
    ru_op_e            op;
    logic              is_read;
    logic [TO_W-1:0]   to_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    assign op = ru_op_e'(cmd_op);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            is_read        <= 1'b0;
            to_cnt         <= '0;
            hold_cnt       <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            ru_read_param  <= 1'b0;
            ru_write_param <= 1'b0;
            ru_param       <= '0;
            ru_read_source <= '0;
            ru_data_in     <= '0;
            ru_reconfig    <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready      <= 1'b0;
                        ru_param       <= cmd_param;
                        ru_read_source <= cmd_src;
                        ru_data_in     <= cmd_data;
                        is_read        <= (op == OP_READ_PARAM);
                        unique case (op)
                            OP_READ_PARAM: begin
                                ru_read_param <= 1'b1;
                                state         <= ST_ISSUE;
                            end
                            OP_WRITE_PARAM: begin
                                ru_write_param <= 1'b1;
                                state          <= ST_ISSUE;
                            end
                            OP_RECONFIG: begin
                                if (cmd_data == RECONFIG_KEY) begin
                                    ru_reconfig <= 1'b1;
                                    hold_cnt    <= '0;
                                    state       <= ST_RECONF;
                                end else begin
                                    rsp_valid <= 1'b1;
                                    rsp_err   <= 1'b1;
                                    rsp_data  <= '0;
                                    state     <= ST_RESP;
                                end
                            end
                            OP_RSVD: begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= 1'b1;
                                rsp_data  <= '0;
                                state     <= ST_RESP;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    ru_read_param  <= 1'b0;
                    ru_write_param <= 1'b0;
                    to_cnt         <= '0;
                    state          <= ST_WAIT_BUSY;
                end
                // Timeout wins if busy only shows up on the last allowed cycle.
                ST_WAIT_BUSY: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (to_cnt == TO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= ST_RESP;
                    end else if (ru_busy) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    to_cnt <= to_cnt + 1'b1;
                    if (!ru_busy) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= is_read ? ru_data_out : '0;
                        state     <= ST_RESP;
                    end else if (to_cnt == TO_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_data  <= '0;
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                // Device reloads from here; only reset brings us back.
                ST_RECONF: begin
                    if (ru_reconfig) begin
                        if (hold_cnt == HOLD_LAST) begin
                            ru_reconfig <= 1'b0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef REMOTE_UPDATE_WDT_EN
    logic wdt_en;

    assign wdt_en = (state != ST_RECONF);

    ru_wdt_kick #(
        .KICK_CYCLES(WDT_KICK_CYCLES)
    ) u_wdt (
        .clk (clk),
        .rst (rst),
        .en  (wdt_en),
        .kick(ru_reset_timer)
    );
`else
    assign ru_reset_timer = 1'b0;
`endif

endmodule

// File: tb/tb_remote_update_ctrl.sv
// Directed self-checking bench for remote_update_ctrl.
module tb_remote_update_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [2:0]  cmd_param;
    logic [1:0]  cmd_src;
    logic [23:0] cmd_data;
    logic        rsp_valid;
    logic [23:0] rsp_data;
    logic        rsp_err;
    logic        ru_read_param;
    logic        ru_write_param;
    logic [2:0]  ru_param;
    logic [1:0]  ru_read_source;
    logic [23:0] ru_data_in;
    logic        ru_reconfig;
    logic        ru_reset_timer;
    logic        ru_busy;
    logic [23:0] ru_data_out;

    int checks = 0;
    int errors = 0;
    int n_rd = 0;
    int n_wr = 0;
    int n_rsp = 0;
    int n_tog = 0;
    logic prev_kick = 1'b0;

    remote_update_ctrl #(
        .BUSY_TIMEOUT   (1024),
        .RECONFIG_KEY   (24'hA5C3E1),
        .RECONFIG_HOLD  (16),
        .WDT_KICK_CYCLES(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_param     (cmd_param),
        .cmd_src       (cmd_src),
        .cmd_data      (cmd_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .ru_read_param (ru_read_param),
        .ru_write_param(ru_write_param),
        .ru_param      (ru_param),
        .ru_read_source(ru_read_source),
        .ru_data_in    (ru_data_in),
        .ru_reconfig   (ru_reconfig),
        .ru_reset_timer(ru_reset_timer),
        .ru_busy       (ru_busy),
        .ru_data_out   (ru_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ru_read_param === 1'b1) n_rd++;
        if (ru_write_param === 1'b1) n_wr++;
        if (rsp_valid === 1'b1) n_rsp++;
        if (ru_reset_timer !== prev_kick) n_tog++;
        prev_kick = ru_reset_timer;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one READ/WRITE with the core busy for busy_n cycles.
    task automatic run_cmd(input string tag, input logic [1:0] op,
                           input logic [2:0] par, input logic [23:0] dat,
                           input int busy_n, input logic [23:0] dout);
        int lat;
        int rd0;
        int wr0;
        logic held;
        rd0 = n_rd;
        wr0 = n_wr;
        held = 1'b1;
        check({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_param = par;
        cmd_src = 2'd1;
        cmd_data = dat;
        tick();
        cmd_valid = 1'b0;
        cmd_param = ~par;
        cmd_src = 2'd2;
        cmd_data = 24'h5A5A5A;
        lat = 1;
        check({tag, "_strobe"}, {ru_read_param, ru_write_param},
              {30'd0, op == 2'd0, op == 2'd1});
        tick();
        lat++;
        ru_busy = 1'b1;
        ru_data_out = 24'hFFFFFF;
        repeat (busy_n) begin
            if (ru_data_in !== dat || ru_param !== par ||
                ru_read_source !== 2'd1) held = 1'b0;
            tick();
            lat++;
        end
        ru_busy = 1'b0;
        ru_data_out = dout;
        tick();
        lat++;
        ru_data_out = 24'h0;
        while (rsp_valid !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, lat, busy_n + 3);
        check({tag, "_err"}, rsp_err, 0);
        check({tag, "_data"}, rsp_data, (op == 2'd0) ? dout : 24'h0);
        check({tag, "_held"}, held, 1);
        check({tag, "_nstrobe"}, (n_rd - rd0) * 16 + (n_wr - wr0),
              (op == 2'd0) ? 16 : 1);
        tick();
        check({tag, "_pulse"}, {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        int n;
        int r0;
        int t0;
        logic v;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_param = 3'd0;
        cmd_src = 2'd0;
        cmd_data = 24'd0;
        ru_busy = 1'b0;
        ru_data_out = 24'd0;
        repeat (3) tick();

        check("rst_ready", cmd_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
        check("rst_strobes", {ru_read_param, ru_write_param, ru_reconfig}, 0);
        check("rst_bus", {ru_param, ru_read_source, ru_data_in}, 0);
        check("rst_kick", ru_reset_timer, 0);
        rst = 1'b0;
        tick();

`ifdef REMOTE_UPDATE_WDT_EN
        v = ru_reset_timer;
        n = 0;
        while (ru_reset_timer === v && n < 30) begin
            tick();
            n++;
        end
        v = ru_reset_timer;
        n = 0;
        while (ru_reset_timer === v && n < 30) begin
            tick();
            n++;
        end
        check("wdt_period", n, 8);
`else
        t0 = n_tog;
        repeat (30) tick();
        check("wdt_off", {n_tog - t0, 31'(ru_reset_timer)}, 0);
`endif

        run_cmd("rd1", 2'd0, 3'b010, 24'h000000, 5, 24'h123456);
        run_cmd("wr2", 2'd1, 3'b100, 24'h0000FF, 3, 24'h777777);
        run_cmd("rdmin", 2'd0, 3'b001, 24'h000000, 1, 24'hC0FFEE);

        cmd_valid = 1'b1;
        cmd_op = 2'd0;
        cmd_param = 3'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        ru_busy = 1'b0;
        ru_data_out = 24'hABCDEF;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        check("to_cycles", n, 1024);
        check("to_err", rsp_err, 1);
        check("to_data", rsp_data, 0);
        tick();
        check("to_ready", cmd_ready, 1);

        cmd_valid = 1'b1;
        cmd_op = 2'd3;
        cmd_data = 24'hA5C3E1;
        tick();
        cmd_valid = 1'b0;
        check("rsvd_rsp", {rsp_valid, rsp_err, rsp_data}, {2'b11, 24'h0});
        tick();

        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_data = 24'h000000;
        tick();
        cmd_valid = 1'b0;
        check("badkey_rsp", {rsp_valid, rsp_err, ru_reconfig}, 3'b110);
        tick();
        check("badkey_idle", {cmd_ready, ru_reconfig}, 2'b10);

        cmd_valid = 1'b1;
        cmd_op = 2'd1;
        cmd_param = 3'd5;
        cmd_data = 24'h00AA00;
        tick();
        cmd_valid = 1'b0;
        tick();
        ru_busy = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("rstwd_ready", cmd_ready, 1);
        check("rstwd_outs", {rsp_valid, ru_write_param, ru_param,
              ru_read_source, ru_data_in}, 0);
        tick();
        rst = 1'b0;
        ru_busy = 1'b0;
        tick();
        run_cmd("after_rst1", 2'd1, 3'b011, 24'h13579B, 2, 24'h0);

        r0 = n_rsp;
        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_data = 24'hA5C3E1;
        tick();
        cmd_op = 2'd0;
        check("rc_ready", cmd_ready, 0);
        n = 0;
        while (ru_reconfig === 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("rc_hold", n, 16);
        t0 = n_tog;
        v = n_rd[0];
        repeat (20) tick();
        check("rc_stuck", {cmd_ready, ru_reconfig, ru_read_param}, 0);
        check("rc_norsp", n_rsp - r0, 0);
        check("rc_nord", n_rd[0], v);
        check("rc_kick_stop", n_tog - t0, 0);
        cmd_valid = 1'b0;

        #2 rst = 1'b1;
        #1;
        check("rstrc_ready", {cmd_ready, ru_reconfig}, 2'b10);
        tick();
        rst = 1'b0;
        tick();

        cmd_valid = 1'b1;
        cmd_op = 2'd2;
        cmd_data = 24'hA5C3E1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("rc2_high", ru_reconfig, 1);
        #2 rst = 1'b1;
        #1;
        check("rstrc2_outs", {cmd_ready, ru_reconfig, rsp_valid}, 3'b100);
        tick();
        rst = 1'b0;
        tick();
        run_cmd("after_rst2", 2'd0, 3'b110, 24'h0, 1, 24'h2468AC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
